// File: rtl/pd_match_referee.sv
// Prisoner's Dilemma match referee: scores both players each round with saturating
// accumulators and declares a winner. Optional history shift register: REFEREE_HISTORY_EN.
module pd_match_referee #(
    parameter int NUM_ROUNDS = 200,
    parameter int ROUND_W    = 16,
    parameter int SCORE_W    = 16,
    parameter int PAY_T      = 5,
    parameter int PAY_R      = 3,
    parameter int PAY_P      = 1,
    parameter int PAY_S      = 0
`ifdef REFEREE_HISTORY_EN
    ,
    parameter int HIST_DEPTH = 8
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               action_A,
    input  logic               action_B,
    output logic               round_valid,
    output logic [ROUND_W-1:0] round,
    output logic [SCORE_W-1:0] score_A,
    output logic [SCORE_W-1:0] score_B,
    output logic [ROUND_W-1:0] coop_both,
    output logic               match_done,
    output logic [1:0]         winner
`ifdef REFEREE_HISTORY_EN
    ,
    output logic [2*HIST_DEPTH-1:0] history
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SCORE_W:0]   P_T       = (SCORE_W+1)'(PAY_T);
    localparam logic [SCORE_W:0]   P_R       = (SCORE_W+1)'(PAY_R);
    localparam logic [SCORE_W:0]   P_P       = (SCORE_W+1)'(PAY_P);
    localparam logic [SCORE_W:0]   P_S       = (SCORE_W+1)'(PAY_S);
    localparam logic [SCORE_W+1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};
    localparam logic [ROUND_W-1:0] LAST      = ROUND_W'(NUM_ROUNDS);

    logic [1:0]         state;
    logic [SCORE_W:0]   pay_a;
    logic [SCORE_W:0]   pay_b;
    logic               both_coop;
    logic [SCORE_W-1:0] next_a;
    logic [SCORE_W-1:0] next_b;
    logic [ROUND_W-1:0] next_round;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                   input logic [SCORE_W:0]   inc);
        logic [SCORE_W+1:0] sum;
        sum = {2'b00, acc} + {1'b0, inc};
        return (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        pay_a     = P_P;
        pay_b     = P_P;
        both_coop = 1'b0;
        case ({action_A, action_B})
            2'b00: begin pay_a = P_R; pay_b = P_R; both_coop = 1'b1; end
            2'b01: begin pay_a = P_S; pay_b = P_T; end
            2'b10: begin pay_a = P_T; pay_b = P_S; end
            default: begin pay_a = P_P; pay_b = P_P; end
        endcase
        next_a     = sat_add(score_A, pay_a);
        next_b     = sat_add(score_B, pay_b);
        next_round = round + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            round_valid <= 1'b0;
            round       <= '0;
            score_A     <= '0;
            score_B     <= '0;
            coop_both   <= '0;
            match_done  <= 1'b0;
            winner      <= 2'b00;
`ifdef REFEREE_HISTORY_EN
            history     <= '0;
`endif
        end else begin
            // NOTE: default pulse value first; only a scored PLAY round raises it.
            round_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_PLAY;
                        round      <= '0;
                        score_A    <= '0;
                        score_B    <= '0;
                        coop_both  <= '0;
                        match_done <= 1'b0;
                        winner     <= 2'b00;
`ifdef REFEREE_HISTORY_EN
                        history    <= '0;
`endif
                    end
                end
                S_PLAY: begin
                    round_valid <= 1'b1;
                    round       <= next_round;
                    score_A     <= next_a;
                    score_B     <= next_b;
                    if (both_coop)
                        coop_both <= coop_both + 1'b1;
`ifdef REFEREE_HISTORY_EN
                    history <= {history[2*HIST_DEPTH-3:0], action_A, action_B};
`endif
                    if (next_round == LAST) begin
                        // Winner decided from the final round's updated scores.
                        state      <= S_DONE;
                        match_done <= 1'b1;
                        if (next_a > next_b)
                            winner <= 2'b01;
                        else if (next_a < next_b)
                            winner <= 2'b10;
                        else
                            winner <= 2'b00;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pd_match_referee.sv
// Randomized scoreboard bench for pd_match_referee with a behavioural payoff model.
module tb_pd_match_referee;

    localparam int NR = 8;
    localparam int RW = 8;
    localparam int SW = 5;
    localparam int SMAX = (1 << SW) - 1;
`ifdef REFEREE_HISTORY_EN
    localparam int HD = 3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          action_A = 1'b0;
    logic          action_B = 1'b0;
    logic          round_valid;
    logic [RW-1:0] round;
    logic [SW-1:0] score_A;
    logic [SW-1:0] score_B;
    logic [RW-1:0] coop_both;
    logic          match_done;
    logic [1:0]    winner;
`ifdef REFEREE_HISTORY_EN
    logic [2*HD-1:0] history;
`endif

    pd_match_referee #(
        .NUM_ROUNDS(NR), .ROUND_W(RW), .SCORE_W(SW),
        .PAY_T(5), .PAY_R(3), .PAY_P(1), .PAY_S(0)
`ifdef REFEREE_HISTORY_EN
        , .HIST_DEPTH(HD)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .action_A(action_A), .action_B(action_B),
        .round_valid(round_valid), .round(round),
        .score_A(score_A), .score_B(score_B), .coop_both(coop_both),
        .match_done(match_done), .winner(winner)
`ifdef REFEREE_HISTORY_EN
        , .history(history)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int round;
        int sa;
        int sb;
        int coop;
        int done;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    int   m_round, m_sa, m_sb, m_coop;
    bit [1:0] m_hist[$];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Payoff for a player given its own and its opponent's action (1 = defect).
    function automatic int payoff(input bit me, input bit other);
        if (!me && !other) return 3;
        if (!me && other)  return 0;
        if (me && !other)  return 5;
        return 1;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int decide(input int a, input int b);
        if (a > b) return 1;
        if (a < b) return 2;
        return 0;
    endfunction

    // Monitor: every scored round must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (round_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_round_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("round", int'(round), e.round);
                check("score_A", int'(score_A), e.sa);
                check("score_B", int'(score_B), e.sb);
                check("coop_both", int'(coop_both), e.coop);
                check("match_done", int'(match_done), e.done);
                check("winner", int'(winner), e.win);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_round_valid"}, int'(round_valid), 0);
        check({tag, "_round"}, int'(round), 0);
        check({tag, "_score_A"}, int'(score_A), 0);
        check({tag, "_score_B"}, int'(score_B), 0);
        check({tag, "_coop_both"}, int'(coop_both), 0);
        check({tag, "_match_done"}, int'(match_done), 0);
        check({tag, "_winner"}, int'(winner), 0);
`ifdef REFEREE_HISTORY_EN
        check({tag, "_history"}, int'(history), 0);
`endif
    endtask

    // mode: 0 all cooperate, 1 A defects, 2 B defects, 3 all defect, 4 random.
    // abort_after > 0 asserts reset after that many scored rounds.
    task automatic run_match(input int mode, input int abort_after);
        bit a, b;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_round = 0; m_sa = 0; m_sb = 0; m_coop = 0;
        m_hist.delete();
        for (int i = 0; i < NR; i++) begin
            case (mode)
                0: begin a = 1'b0; b = 1'b0; end
                1: begin a = 1'b1; b = 1'b0; end
                2: begin a = 1'b0; b = 1'b1; end
                3: begin a = 1'b1; b = 1'b1; end
                default: begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
            endcase
            action_A = a;
            action_B = b;
            start = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_round++;
            m_sa = min_int(m_sa + payoff(a, b), SMAX);
            m_sb = min_int(m_sb + payoff(b, a), SMAX);
            if (!a && !b) m_coop++;
            m_hist.push_front({a, b});
            e.round = m_round; e.sa = m_sa; e.sb = m_sb; e.coop = m_coop;
            e.done = (m_round == NR) ? 1 : 0;
            e.win = (m_round == NR) ? decide(m_sa, m_sb) : 0;
            exp_q.push_back(e);
            @(negedge clk);
            if (abort_after > 0 && m_round == abort_after) begin
                start = 1'b0;
                #2 reset = 1'b1;
                #1;
                check_all_zero("mid_reset");
                check("mid_reset_queue", exp_q.size(), 0);
                exp_q.delete();
                @(negedge clk);
                reset = 1'b0;
                repeat (3) @(negedge clk);
                check_all_zero("after_release");
                return;
            end
        end
        start = 1'b0;
        check("end_match_done", int'(match_done), 1);
        check("end_winner", int'(winner), decide(m_sa, m_sb));
        check("end_round", int'(round), NR);
        check("end_score_A", int'(score_A), m_sa);
        check("end_score_B", int'(score_B), m_sb);
        check("end_queue_empty", exp_q.size(), 0);
`ifdef REFEREE_HISTORY_EN
        begin
            logic [2*HD-1:0] hv;
            hv = '0;
            for (int j = 0; j < HD && j < m_hist.size(); j++)
                hv[2*j +: 2] = m_hist[j];
            check("end_history", int'(history), int'(hv));
        end
`endif
        // Frozen in DONE while start stays low.
        @(negedge clk);
        check("done_hold_round", int'(round), NR);
        check("done_hold_match_done", int'(match_done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("idle_no_start");

        run_match(0, 0);
        run_match(1, 0);
        run_match(2, 0);
        run_match(3, 0);
        run_match(0, 0);
        for (int k = 0; k < 6; k++) run_match(4, 0);
        run_match(4, 5);
        run_match(1, 0);
        run_match(4, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pd_match_referee.md
# pd_match_referee

Scoring stage directly downstream of the strategy player. Samples both players' per-round actions once per clock, applies the Prisoner's Dilemma payoff matrix, and keeps saturating scores and round/cooperation tallies. Ends the match after a fixed number of rounds and reports the winner. Sits between the two player blocks and the top-level result logic.

## Interface

- NUM_ROUNDS, 200: rounds per match (≥1).
- ROUND_W, 16: width of round counter; NUM_ROUNDS < 2^ROUND_W.
- SCORE_W, 16: width of each score accumulator.
- PAY_T, 5: temptation payoff (defector vs cooperator).
- PAY_R, 3: reward payoff (mutual cooperate).
- PAY_P, 1: punishment payoff (mutual defect).
- PAY_S, 0: sucker payoff (cooperator vs defector).
- HIST_DEPTH, 8: rounds retained in history (only with REFEREE_HISTORY_EN).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin/restart a match; honoured in IDLE and DONE only.
- action_A  input  1  player A action, 0 = cooperate, 1 = defect.
- action_B  input  1  player B action, same encoding.
- round_valid  output  1  one-cycle pulse per scored round.
- round  output  ROUND_W  rounds scored so far this match.
- score_A  output  SCORE_W  accumulated A payoff.
- score_B  output  SCORE_W  accumulated B payoff.
- coop_both  output  ROUND_W  count of mutual-cooperate rounds.
- match_done  output  1  high while in DONE.
- winner  output  2  00 tie/not done, 01 A wins, 10 B wins; 11 never driven.
- history  output  2*HIST_DEPTH  {A,B} action pairs, newest in bits [1:0] (with REFEREE_HISTORY_EN only).

## Operation

- States: IDLE, PLAY, DONE. Reset → IDLE.
- IDLE: outputs hold; start=1 → PLAY; on that edge round, score_A, score_B, coop_both, history cleared.
- PLAY: each rising edge samples action_A/action_B (players change actions on falling edge, so inputs are stable at the rising edge). Same edge: round += 1, round_valid = 1, payoffs added:
  - 0/0: A += PAY_R, B += PAY_R, coop_both += 1.
  - 0/1: A += PAY_S, B += PAY_T.
  - 1/0: A += PAY_T, B += PAY_S.
  - 1/1: A += PAY_P, B += PAY_P.
- start ignored in PLAY.
- Edge where round becomes NUM_ROUNDS → DONE; that round is scored normally.
- DONE: match_done = 1, round_valid = 0, counters frozen; winner = 01 if score_A > score_B, 10 if less, 00 if equal. start=1 → clear as in IDLE, PLAY.
- Arithmetic: payoffs zero-extended to SCORE_W; sum saturates at 2^SCORE_W−1 and stays there. Round/coop_both never overflow by parameter rule.
- winner = 00 whenever not in DONE.

## Timing

- Reset values: round_valid 0, round 0, score_A 0, score_B 0, coop_both 0, match_done 0, winner 00, history 0; state IDLE. Asynchronous assertion takes effect immediately, including mid-match; outputs are not restored on release.
- start accepted at edge k → first round sampled at edge k+1, last at edge k+NUM_ROUNDS; match_done and winner are valid after edge k+NUM_ROUNDS.
- All outputs registered; zero combinational paths from inputs to outputs.
- round_valid high for exactly NUM_ROUNDS consecutive cycles per match.
- start held high through DONE restarts immediately at the first DONE edge seen; DONE lasts ≥1 cycle.

## Configuration

- REFEREE_HISTORY_EN defined: history port present; each scored round shifts {action_A, action_B} into bits [1:0], older pairs move up by 2, oldest discarded; cleared on reset and start acceptance, frozen in IDLE/DONE.
- Not defined: history port and shift register absent; all other behaviour identical.

## Test plan

- NUM_ROUNDS=4, A=0, B=0 every round → round_valid 4 cycles, score_A=12, score_B=12, coop_both=4, winner=00, match_done=1.
- NUM_ROUNDS=4, A=1, B=0 → score_A=20, score_B=0, coop_both=0, winner=01.
- SCORE_W=4, NUM_ROUNDS=4, A=0, B=1 → score_B saturates at 15 (not 4), score_A=0, winner=10.
- NUM_ROUNDS=200, reset asserted after round 57 → all outputs 0 immediately, IDLE; start pulse then gives a fresh 200-round match, round=200 at done.
- From DONE (score 12/12), start=1 with A=1, B=1 ×4 → scores cleared, end at 4/4, winner=00; start during PLAY has no effect.
- REFEREE_HISTORY_EN, HIST_DEPTH=2, pairs (0,1),(1,1),(1,0) → history = 4'b1110; without the macro, port absent and build clean.
